reg_bank16_wr: RTL and testbench
================================

Name: reg_bank16_wr

Overview:
- Write-side counterpart of the 16:1 register-select mux in the ARMv4 datapath.
- Decodes a 4-bit register address into one of 16 register write enables: R0-R14 in the bank, R15 in the PC register.
- Adds a load-multiple (LDM-style) burst sequencer that writes consecutive data beats into the registers selected by a 16-bit mask, in ascending order.
- Provides two combinational read ports with ARM PC+8 semantics on R15.

Parameters:
WIDTH, 32, data width of every register and data port
PC_OFFSET, 8, value added to pc when R15 is read

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
we  in  1  single-register write enable
wa  in  4  single-write register address
wd  in  WIDTH  single-write data
lm_start  in  1  start load-multiple burst (IDLE only)
lm_mask  in  16  register list; bit n selects Rn
lm_data  in  WIDTH  burst data beat
lm_valid  in  1  burst beat valid
lm_ready  out  1  sequencer accepts a beat this cycle
lm_busy  out  1  burst in progress
lm_done  out  1  one-cycle pulse after the final beat, or after a zero-mask start
pc_en  in  1  advance PC to pc_next
pc_next  in  WIDTH  next sequential PC
pc  out  WIDTH  current PC (R15 storage)
ra1  in  4  read address port 1
ra2  in  4  read address port 2
rd1  out  WIDTH  read data port 1
rd2  out  WIDTH  read data port 2

Behaviour:
- Reset (async, active-high): R0-R14 = 0, pc = 0, state = IDLE, lm_ready = 0, lm_busy = 0, lm_done = 0. Reset mid-burst aborts the burst; no further writes occur and no lm_done pulse is produced.
- Reads: combinational. rdN = R[raN] for raN < 15. rdN = pc + PC_OFFSET (mod 2^WIDTH) for raN = 15.
- Single write: in IDLE with we = 1, the bank is updated at the clock edge.
  - wa < 15: R[wa] <= wd.
  - wa = 15: pc <= wd. This write overrides pc_en in the same cycle.
- we is ignored whenever lm_busy = 1 or the FSM leaves IDLE that cycle; no write is performed.
- PC update: pc <= pc_next when pc_en = 1 and no R15 write occurs in that cycle. Otherwise pc holds.
- FSM state IDLE:
  - lm_ready = 0, lm_busy = 0.
  - lm_start = 1 with lm_mask != 0: go to BURST; pend <= lm_mask.
  - lm_start = 1 with lm_mask = 0: stay in IDLE; lm_done = 1 on the next cycle.
  - lm_start has priority over we: the single write in that cycle is dropped.
- FSM state BURST:
  - lm_ready = 1, lm_busy = 1.
  - On lm_valid = 1: n = lowest set bit of pend. Write R[n] <= lm_data (n = 15 writes pc and overrides pc_en), then clear bit n in pend.
  - If pend had exactly one bit set: go to IDLE; lm_done = 1 for one cycle on the next cycle.
  - lm_valid = 0: no write; state holds (stall of any length is allowed).
  - lm_start is ignored while in BURST.
- lm_done is registered: high exactly one cycle, in the cycle after the last accepted beat.
- Arithmetic: no width extension. The pc + PC_OFFSET add wraps modulo 2^WIDTH.

Optional Feature:
- Macro: RF_BYPASS_EN.
- Defined: a read of register X returns the data being written to X in the same cycle (single write or burst beat, R15 included; for R15 the result is write data + PC_OFFSET). The read is combinational forwarding from wd or lm_data.
- Not defined: reads return the pre-edge register contents. The new value is visible from the cycle after the write edge.

Test Plan:
- Reset, then ra1 = 3, ra2 = 15 -> rd1 = 0, rd2 = 8. Hold pc_en = 1 with pc_next = 4 -> pc = 4, rd2 = 12.
- Single writes: we = 1, wa = 5, wd = 0xA5A5A5A5; then wa = 15, wd = 0x100 while pc_en = 1, pc_next = 0x44 -> R5 = 0xA5A5A5A5, pc = 0x100 (write wins over pc_en).
- Burst: lm_mask = 0x8012, beats 0x11, 0x22, 0x33 with one idle cycle between beats 1 and 2 -> R1 = 0x11, R4 = 0x22, pc = 0x33. lm_done pulses once, the cycle after beat 3. lm_busy is high for the whole burst.
- Zero mask plus we collision: lm_start = 1, lm_mask = 0, we = 1, wa = 2, wd = 7 -> no state change, R2 unchanged, lm_done = 1 next cycle. During a burst, we = 1, wa = 2 -> R2 unchanged.
- Assert reset after the first beat of mask 0x000F -> R0 = 0, lm_busy = 0, no lm_done pulse. A later lm_start is accepted normally.
- Same-cycle write/read of R7 (ra1 = 7, we = 1, wa = 7, wd = 9, old value 0):
  - RF_BYPASS_EN defined -> rd1 = 9 in that cycle.
  - RF_BYPASS_EN undefined -> rd1 = 0 in that cycle, 9 in the next.

Source files
------------

// File: rtl/reg_bank16_wr_if.sv
// reg_bank16_wr_if -- bus bundle for the ARMv4 register bank write side.
//   master : drives writes, burst control, PC update and read addresses
//   slave  : the register bank; returns burst status, pc and read data
// Signals:
//   we/wa/wd                   single-register write
//   lm_start/lm_mask           load-multiple burst start and register list
//   lm_data/lm_valid           burst data beats
//   lm_ready/lm_busy/lm_done   burst status
//   pc_en/pc_next/pc           PC advance and current PC
//   ra1/ra2/rd1/rd2            two combinational read ports
interface reg_bank16_wr_if #(
    parameter int WIDTH = 32
);
    logic             we;
    logic [3:0]       wa;
    logic [WIDTH-1:0] wd;
    logic             lm_start;
    logic [15:0]      lm_mask;
    logic [WIDTH-1:0] lm_data;
    logic             lm_valid;
    logic             lm_ready;
    logic             lm_busy;
    logic             lm_done;
    logic             pc_en;
    logic [WIDTH-1:0] pc_next;
    logic [WIDTH-1:0] pc;
    logic [3:0]       ra1;
    logic [3:0]       ra2;
    logic [WIDTH-1:0] rd1;
    logic [WIDTH-1:0] rd2;

    modport master (
        output we, wa, wd, lm_start, lm_mask, lm_data, lm_valid,
               pc_en, pc_next, ra1, ra2,
        input  lm_ready, lm_busy, lm_done, pc, rd1, rd2
    );

    modport slave (
        input  we, wa, wd, lm_start, lm_mask, lm_data, lm_valid,
               pc_en, pc_next, ra1, ra2,
        output lm_ready, lm_busy, lm_done, pc, rd1, rd2
    );
endinterface

// File: rtl/reg_bank16_wr.sv
// reg_bank16_wr -- ARMv4 register bank write side: R0-R14 bank plus R15 (pc),
// single-register writes, an ascending-order load-multiple burst sequencer,
// and two combinational read ports where R15 reads as pc + PC_OFFSET.
// Ports:
//   clk   : system clock, rising edge
//   reset : asynchronous, active-high reset
//   bus   : reg_bank16_wr_if.slave (writes, burst, pc update, read ports)
// Build option:
//   RF_BYPASS_EN : when defined, a read of the register being written this
//                  cycle returns the incoming write data (R15: data + offset).
module reg_bank16_wr #(
    parameter int WIDTH     = 32,
    parameter int PC_OFFSET = 8
) (
    input  logic           clk,
    input  logic           reset,
    reg_bank16_wr_if.slave bus
);
    typedef enum logic {IDLE, BURST} state_t;

    localparam logic [WIDTH-1:0] OFS = WIDTH'(PC_OFFSET);

    state_t           state, state_nxt;
    logic [15:0]      pend, pend_nxt;
    logic             done_q, done_nxt;
    logic [WIDTH-1:0] regs [15];
    logic [WIDTH-1:0] pc_q;

    // Merged write request: at most one register is written per cycle,
    // either from the single-write port or from a burst beat.
    logic             wr_en;
    logic [3:0]       wr_a;
    logic [WIDTH-1:0] wr_d;
    logic [15:0]      wen;

    // Lowest pending register and whether it is the last one.
    logic [15:0]      low_oh;
    logic [3:0]       low_idx;
    logic             last_beat;

    always_comb begin
        low_oh    = pend & (~pend + 16'd1);
        last_beat = (pend & (pend - 16'd1)) == 16'd0;
        low_idx   = 4'd0;
        for (int i = 15; i >= 0; i--)
            if (pend[i]) low_idx = 4'(i);
    end

    always_comb begin
        state_nxt = state;
        pend_nxt  = pend;
        done_nxt  = 1'b0;
        wr_en     = 1'b0;
        wr_a      = bus.wa;
        wr_d      = bus.wd;
        unique case (state)
            IDLE: begin
                // lm_start wins over we; the single write is dropped.
                if (bus.lm_start) begin
                    if (bus.lm_mask != 16'd0) begin
                        state_nxt = BURST;
                        pend_nxt  = bus.lm_mask;
                    end else begin
                        done_nxt  = 1'b1;
                    end
                end else if (bus.we) begin
                    wr_en = 1'b1;
                end
            end
            BURST: begin
                if (bus.lm_valid) begin
                    wr_en    = 1'b1;
                    wr_a     = low_idx;
                    wr_d     = bus.lm_data;
                    pend_nxt = pend & ~low_oh;
                    if (last_beat) begin
                        state_nxt = IDLE;
                        done_nxt  = 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
        wen = wr_en ? (16'd1 << wr_a) : 16'd0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            pend   <= 16'd0;
            done_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            pend   <= pend_nxt;
            done_q <= done_nxt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 15; i++) regs[i] <= '0;
            pc_q <= '0;
        end else begin
            for (int i = 0; i < 15; i++)
                if (wen[i]) regs[i] <= wr_d;
            // An R15 write always beats the sequential PC advance.
            if (wen[15])        pc_q <= wr_d;
            else if (bus.pc_en) pc_q <= bus.pc_next;
        end
    end

    // Architectural view of all 16 registers as seen by a read.
    logic [15:0][WIDTH-1:0] view;

    always_comb begin
        for (int i = 0; i < 15; i++) view[i] = regs[i];
        view[15] = pc_q + OFS;
`ifdef RF_BYPASS_EN
        if (wr_en) view[wr_a] = (wr_a == 4'd15) ? wr_d + OFS : wr_d;
`endif
    end

    assign bus.rd1      = view[bus.ra1];
    assign bus.rd2      = view[bus.ra2];
    assign bus.pc       = pc_q;
    assign bus.lm_ready = (state == BURST);
    assign bus.lm_busy  = (state == BURST);
    assign bus.lm_done  = done_q;
endmodule

// File: tb/tb_reg_bank16_wr.sv
// tb_reg_bank16_wr -- directed bench for reg_bank16_wr: reset values, pc
// advance, single writes, burst with stall, zero-mask start, write collisions,
// reset abort mid-burst and same-cycle write/read behaviour.
module tb_reg_bank16_wr;
    localparam int W = 32;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_chk = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    reg_bank16_wr_if #(.WIDTH(W)) bus ();

    reg_bank16_wr #(.WIDTH(W), .PC_OFFSET(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.we = 0; bus.wa = 0; bus.wd = 0;
        bus.lm_start = 0; bus.lm_mask = 0; bus.lm_data = 0; bus.lm_valid = 0;
        bus.pc_en = 0; bus.pc_next = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        bus.ra1 = 4'd3; bus.ra2 = 4'd15;
        reset = 1'b1;
        step(); step();
        n_chk++; if (bus.rd1 !== 32'h0) begin n_fail++; $display("FAIL reset_rd1 got %h want %h", bus.rd1, 32'h0); end
        n_chk++; if (bus.rd2 !== 32'h8) begin n_fail++; $display("FAIL reset_rd2 got %h want %h", bus.rd2, 32'h8); end
        n_chk++; if ({bus.lm_ready, bus.lm_busy, bus.lm_done} !== 3'b000) begin n_fail++; $display("FAIL reset_status got %b want 000", {bus.lm_ready, bus.lm_busy, bus.lm_done}); end
        reset = 1'b0;
        bus.pc_en = 1; bus.pc_next = 32'h4;
        step();
        bus.pc_en = 0;
        n_chk++; if (bus.pc !== 32'h4) begin n_fail++; $display("FAIL pc_adv got %h want %h", bus.pc, 32'h4); end
        n_chk++; if (bus.rd2 !== 32'hC) begin n_fail++; $display("FAIL pc_adv_rd2 got %h want %h", bus.rd2, 32'hC); end
    endtask

    task automatic test_single_write();
        bus.we = 1; bus.wa = 4'd5; bus.wd = 32'hA5A5A5A5;
        step();
        bus.wa = 4'd15; bus.wd = 32'h100; bus.pc_en = 1; bus.pc_next = 32'h44;
        step();
        idle_inputs();
        bus.ra1 = 4'd5; bus.ra2 = 4'd15;
        #1;
        n_chk++; if (bus.rd1 !== 32'hA5A5A5A5) begin n_fail++; $display("FAIL wr_r5 got %h want %h", bus.rd1, 32'hA5A5A5A5); end
        n_chk++; if (bus.pc !== 32'h100) begin n_fail++; $display("FAIL wr_pc_wins got %h want %h", bus.pc, 32'h100); end
        n_chk++; if (bus.rd2 !== 32'h108) begin n_fail++; $display("FAIL wr_pc_rd2 got %h want %h", bus.rd2, 32'h108); end
    endtask

    task automatic test_burst();
        bus.lm_start = 1; bus.lm_mask = 16'h8012;
        step();
        bus.lm_start = 0; bus.lm_mask = 0;
        n_chk++; if ({bus.lm_ready, bus.lm_busy} !== 2'b11) begin n_fail++; $display("FAIL burst_enter got %b want 11", {bus.lm_ready, bus.lm_busy}); end
        bus.lm_valid = 1; bus.lm_data = 32'h11;
        step();
        n_chk++; if ({bus.lm_busy, bus.lm_done} !== 2'b10) begin n_fail++; $display("FAIL burst_beat1 got %b want 10", {bus.lm_busy, bus.lm_done}); end
        // stall cycle, with a colliding single write to R2 that must be dropped
        bus.lm_valid = 0; bus.we = 1; bus.wa = 4'd2; bus.wd = 32'hDEAD;
        step();
        bus.we = 0;
        n_chk++; if (bus.lm_busy !== 1'b1) begin n_fail++; $display("FAIL burst_stall_busy got %b want 1", bus.lm_busy); end
        bus.lm_valid = 1; bus.lm_data = 32'h22;
        step();
        n_chk++; if ({bus.lm_busy, bus.lm_done} !== 2'b10) begin n_fail++; $display("FAIL burst_beat2 got %b want 10", {bus.lm_busy, bus.lm_done}); end
        bus.lm_data = 32'h33;
        step();
        idle_inputs();
        n_chk++; if ({bus.lm_busy, bus.lm_done} !== 2'b01) begin n_fail++; $display("FAIL burst_done got %b want 01", {bus.lm_busy, bus.lm_done}); end
        bus.ra1 = 4'd1; bus.ra2 = 4'd4;
        #1;
        n_chk++; if (bus.rd1 !== 32'h11) begin n_fail++; $display("FAIL burst_r1 got %h want %h", bus.rd1, 32'h11); end
        n_chk++; if (bus.rd2 !== 32'h22) begin n_fail++; $display("FAIL burst_r4 got %h want %h", bus.rd2, 32'h22); end
        n_chk++; if (bus.pc !== 32'h33) begin n_fail++; $display("FAIL burst_pc got %h want %h", bus.pc, 32'h33); end
        bus.ra1 = 4'd2;
        #1;
        n_chk++; if (bus.rd1 !== 32'h0) begin n_fail++; $display("FAIL burst_we_dropped got %h want %h", bus.rd1, 32'h0); end
        step();
        n_chk++; if (bus.lm_done !== 1'b0) begin n_fail++; $display("FAIL burst_done_pulse got %b want 0", bus.lm_done); end
    endtask

    task automatic test_zero_mask();
        bus.lm_start = 1; bus.lm_mask = 16'h0; bus.we = 1; bus.wa = 4'd2; bus.wd = 32'h7;
        step();
        idle_inputs();
        bus.ra1 = 4'd2;
        #1;
        n_chk++; if ({bus.lm_busy, bus.lm_done} !== 2'b01) begin n_fail++; $display("FAIL zmask_done got %b want 01", {bus.lm_busy, bus.lm_done}); end
        n_chk++; if (bus.rd1 !== 32'h0) begin n_fail++; $display("FAIL zmask_r2 got %h want %h", bus.rd1, 32'h0); end
        step();
        n_chk++; if (bus.lm_done !== 1'b0) begin n_fail++; $display("FAIL zmask_pulse got %b want 0", bus.lm_done); end
    endtask

    task automatic test_reset_abort();
        int seen_done;
        bus.lm_start = 1; bus.lm_mask = 16'h000F;
        step();
        bus.lm_start = 0; bus.lm_mask = 0;
        bus.lm_valid = 1; bus.lm_data = 32'h55;
        step();
        bus.lm_valid = 0;
        reset = 1'b1;
        #1;
        bus.ra1 = 4'd0;
        #1;
        n_chk++; if (bus.rd1 !== 32'h0) begin n_fail++; $display("FAIL abort_r0 got %h want %h", bus.rd1, 32'h0); end
        n_chk++; if ({bus.lm_ready, bus.lm_busy} !== 2'b00) begin n_fail++; $display("FAIL abort_busy got %b want 00", {bus.lm_ready, bus.lm_busy}); end
        step();
        reset = 1'b0;
        seen_done = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (bus.lm_done) seen_done++;
        end
        n_chk++; if (seen_done !== 0) begin n_fail++; $display("FAIL abort_no_done got %0d want 0", seen_done); end
        bus.lm_start = 1; bus.lm_mask = 16'h0001;
        step();
        bus.lm_start = 0; bus.lm_mask = 0;
        n_chk++; if (bus.lm_busy !== 1'b1) begin n_fail++; $display("FAIL restart_busy got %b want 1", bus.lm_busy); end
        bus.lm_valid = 1; bus.lm_data = 32'h77;
        step();
        idle_inputs();
        #1;
        n_chk++; if ({bus.lm_busy, bus.lm_done} !== 2'b01) begin n_fail++; $display("FAIL restart_done got %b want 01", {bus.lm_busy, bus.lm_done}); end
        n_chk++; if (bus.rd1 !== 32'h77) begin n_fail++; $display("FAIL restart_r0 got %h want %h", bus.rd1, 32'h77); end
        step();
    endtask

    task automatic test_bypass();
        logic [W-1:0] exp_now, exp_pc;
`ifdef RF_BYPASS_EN
        exp_now = 32'h9;
        exp_pc  = 32'h208;
`else
        exp_now = 32'h0;
        exp_pc  = 32'h8;
`endif
        bus.ra1 = 4'd7; bus.we = 1; bus.wa = 4'd7; bus.wd = 32'h9;
        #1;
        n_chk++; if (bus.rd1 !== exp_now) begin n_fail++; $display("FAIL byp_r7_same got %h want %h", bus.rd1, exp_now); end
        step();
        bus.we = 0;
        #1;
        n_chk++; if (bus.rd1 !== 32'h9) begin n_fail++; $display("FAIL byp_r7_next got %h want %h", bus.rd1, 32'h9); end
        // pc is 0 here: the reset abort cleared it and nothing wrote it since
        bus.ra2 = 4'd15; bus.we = 1; bus.wa = 4'd15; bus.wd = 32'h200;
        #1;
        n_chk++; if (bus.rd2 !== exp_pc) begin n_fail++; $display("FAIL byp_pc_same got %h want %h", bus.rd2, exp_pc); end
        step();
        bus.we = 0;
        #1;
        n_chk++; if (bus.rd2 !== 32'h208) begin n_fail++; $display("FAIL byp_pc_next got %h want %h", bus.rd2, 32'h208); end
    endtask

    initial begin
        idle_inputs();
        bus.ra1 = 0; bus.ra2 = 0;
        test_reset();
        test_single_write();
        test_burst();
        test_zero_mask();
        test_reset_abort();
        test_bypass();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
